// File: rtl/div5_restoring.sv
`default_nettype none
// ============================================================================
//  Module   : div5_restoring
//  Purpose  : Sequential unsigned restoring divider. One trial subtraction per
//             clock through a WIDTH+1 bit ripple subtract stage. The block
//             produces quotient and remainder behind a start/busy/done
//             handshake.
//  Options  : DIV5_ZERO_CHECK_EN - a zero divisor completes in one cycle
//             with quotient all ones, remainder = dividend and div_err set.
//             When the macro is undefined, div_err is tied low and a zero
//             divisor runs the normal WIDTH iterations.
//  Revision : 1.0 - initial release
// ============================================================================
module div5_restoring #(
    parameter int WIDTH = 5   // operand/result width, also the iteration count (>= 3)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_err
);

    localparam int             C_CNT_W = $clog2(WIDTH);
    localparam logic [C_CNT_W-1:0] C_LAST_ITER = C_CNT_W'(WIDTH - 1);

    localparam logic [0:0] c_idle = 1'b0;
    localparam logic [0:0] c_run  = 1'b1;

    logic [0:0]         r_state;
    logic [WIDTH-1:0]   r_n;      // dividend, shifted out MSB first
    logic [WIDTH-1:0]   r_d;      // captured divisor
    logic [WIDTH-1:0]   r_rem;    // partial remainder after restore (always < D)
    logic [WIDTH-2:0]   r_q;      // quotient bits gathered so far; last bit goes straight out
    logic [C_CNT_W-1:0] r_cnt;    // iterations remaining after the current one

    // Trial operand: the previous remainder shifted left, with the next dividend bit appended.
    // It is WIDTH+1 bits wide. After a restore the remainder is < D, so the top bit of
    // the stored remainder is always zero and is not kept.
    logic [WIDTH:0]   w_t_in;
    logic [WIDTH:0]   w_sub_b;
    logic [WIDTH+1:0] w_carry;
    logic [WIDTH-1:0] w_diff;
    logic             w_no_borrow;
    logic [WIDTH-1:0] w_r_sel;

    assign w_t_in     = {r_rem, r_n[WIDTH-1]};
    assign w_sub_b    = ~{1'b0, r_d};
    assign w_carry[0] = 1'b1;

    // Ripple subtract stage: T_in + ~{0,D} + 1. A carry-out of 1 means no borrow.
    generate
        for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_sub
            assign w_carry[gi+1] = (w_t_in[gi] & w_sub_b[gi]) |
                                   (w_carry[gi] & (w_t_in[gi] ^ w_sub_b[gi]));
            if (gi < WIDTH) begin : g_diff
                assign w_diff[gi] = w_t_in[gi] ^ w_sub_b[gi] ^ w_carry[gi];
            end
        end
    endgenerate

    assign w_no_borrow = w_carry[WIDTH+1];
    // When no borrow occurs the difference is < D and fits in WIDTH bits. On a borrow,
    // T_in < D, so its top bit is zero.
    assign w_r_sel     = w_no_borrow ? w_diff : w_t_in[WIDTH-1:0];

`ifdef DIV5_ZERO_CHECK_EN
    logic r_zero;   // the accepted division has a zero divisor
`else
    assign div_err = 1'b0;
`endif

    // Control FSM, iteration datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_idle;
            r_n       <= '0;
            r_d       <= '0;
            r_rem     <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIV5_ZERO_CHECK_EN
            r_zero    <= 1'b0;
            div_err   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_n     <= dividend;
                        r_d     <= divisor;
                        r_rem   <= '0;
                        r_q     <= '0;
                        r_cnt   <= C_LAST_ITER;
                        busy    <= 1'b1;
                        r_state <= c_run;
`ifdef DIV5_ZERO_CHECK_EN
                        r_zero  <= (divisor == '0);
`endif
                    end
                end

                c_run: begin
`ifdef DIV5_ZERO_CHECK_EN
                    if (r_zero) begin
                        quotient  <= '1;
                        remainder <= r_n;
                        div_err   <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        r_zero    <= 1'b0;
                        r_state   <= c_idle;
                    end else begin
`else
                    begin
`endif
                        r_n   <= {r_n[WIDTH-2:0], 1'b0};
                        r_rem <= w_r_sel;
                        r_q   <= {r_q[WIDTH-3:0], w_no_borrow};
                        if (r_cnt == '0) begin
                            quotient  <= {r_q, w_no_borrow};
                            remainder <= w_r_sel;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            r_state   <= c_idle;
`ifdef DIV5_ZERO_CHECK_EN
                            div_err   <= 1'b0;
`endif
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end

                default: r_state <= c_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div5_restoring.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div5_restoring
//  Purpose  : Directed self-checking bench for div5_restoring
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div5_restoring;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] dividend;
    logic [4:0] divisor;
    logic       busy;
    logic       done;
    logic [4:0] quotient;
    logic [4:0] remainder;
    logic       div_err;

    int n_asserts = 0;
    int n_fail    = 0;

    div5_restoring #(.WIDTH(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_err   (div_err)
    );

    always #5 clk = ~clk;

`ifdef DIV5_ZERO_CHECK_EN
    localparam int ZLAT = 1;
    localparam int ZERR = 1;
`else
    localparam int ZLAT = 5;
    localparam int ZERR = 0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait for done. lat counts the edges since the caller's last tick. 99 means timeout.
    task automatic wait_done(output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            tick();
            lat++;
            if (done === 1'b1) got = 1'b1;
        end
        if (!got) lat = 99;
    endtask

    task automatic run_div(input string tag, input int n, input int d,
                           input int eq, input int er, input int eerr, input int elat);
        int lat;
        dividend = 5'(n);
        divisor  = 5'(d);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = 5'd30;   // changes after the accepting edge must not matter
        divisor  = 5'd3;
        chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
        wait_done(lat);
        chk({tag, "_latency"}, lat, elat);
        chk({tag, "_quot"}, 32'(quotient), eq);
        chk({tag, "_rem"}, 32'(remainder), er);
        chk({tag, "_err"}, 32'(div_err), eerr);
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        tick();
        chk({tag, "_done_fall"}, 32'(done), 32'd0);
        chk({tag, "_quot_hold"}, 32'(quotient), eq);
    endtask

    initial begin
        int lat;
        int n_done;
        int first_q;
        int first_r;

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_quot", 32'(quotient), 0);
        chk("rst_rem", 32'(remainder), 0);
        chk("rst_err", 32'(div_err), 0);
        reset = 1'b0;
        tick();

        // Basic and edge operands
        run_div("d23_5", 23, 5, 4, 3, 0, 5);
        run_div("d31_1", 31, 1, 31, 0, 0, 5);
        run_div("d3_7", 3, 7, 0, 3, 0, 5);
        run_div("d0_9", 0, 9, 0, 0, 0, 5);

        // Back-to-back: start stays high through the done cycle
        dividend = 5'd20;
        divisor  = 5'd6;
        start    = 1'b1;
        tick();
        chk("b2b_busy_e0", 32'(busy), 1);
        dividend = 5'd17;
        divisor  = 5'd17;
        wait_done(lat);
        chk("b2b1_latency", lat, 5);
        chk("b2b1_quot", 32'(quotient), 3);
        chk("b2b1_rem", 32'(remainder), 2);
        tick();
        chk("b2b2_busy_accept", 32'(busy), 1);
        chk("b2b2_done_low", 32'(done), 0);
        start = 1'b0;
        wait_done(lat);
        chk("b2b2_latency", lat, 5);
        chk("b2b2_quot", 32'(quotient), 1);
        chk("b2b2_rem", 32'(remainder), 0);
        tick();

        // Start pulse during busy is ignored
        dividend = 5'd23;
        divisor  = 5'd5;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        dividend = 5'd9;
        divisor  = 5'd2;
        start    = 1'b1;
        tick();
        start   = 1'b0;
        n_done  = 0;
        first_q = -1;
        first_r = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) begin
                if (n_done == 0) begin
                    first_q = int'(quotient);
                    first_r = int'(remainder);
                end
                n_done++;
            end
        end
        chk("ign_done_count", n_done, 1);
        chk("ign_quot", first_q, 4);
        chk("ign_rem", first_r, 3);
        chk("ign_idle_busy", 32'(busy), 0);

        // Reset in the middle of a run
        dividend = 5'd23;
        divisor  = 5'd5;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_done", 32'(done), 0);
        chk("mrst_quot", 32'(quotient), 0);
        chk("mrst_rem", 32'(remainder), 0);
        chk("mrst_err", 32'(div_err), 0);
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        chk("mrst_no_done", n_done, 0);
        run_div("d14_4", 14, 4, 3, 2, 0, 5);

        // Divide by zero, then a normal division clears div_err
        run_div("d13_0", 13, 0, 31, 13, ZERR, ZLAT);
        run_div("d23_5b", 23, 5, 4, 3, 0, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
